cic_decim_ctrl: RTL and testbench

- Sequencing controller for the CIC decimation datapath.
- Generates the integrator and comb clock enables from the input sample strobe, and owns a runtime-programmable decimation ratio.
- Applies ratio changes only on a decimation boundary and suppresses output until the comb pipeline has settled.
- Presents decimated samples to the downstream consumer through a valid/ready handshake with overrun detection.

---
 rtl/cic_decim_ctrl.sv | 145 ++++++++++++++
 tb/tb_cic_decim_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencing: integrator/comb enables,
// boundary-aligned ratio changes, comb settle flush and output valid/ready.
module cic_decim_ctrl #(
  parameter int RW       = 16,
  parameter int STAGES   = 4,
  parameter int DEF_RATE = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_ce,
  input  logic [RW-1:0] i_rate,
  input  logic          i_rate_load,
  input  logic          i_ready,
  output logic          o_int_ce,
  output logic          o_comb_ce,
  output logic [RW-1:0] o_phase,
  output logic [RW-1:0] o_rate,
  output logic          o_valid,
  output logic [1:0]    o_state,
  output logic          o_overrun,
  output logic          o_rate_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int FW = (STAGES < 2) ? 1 : $clog2(STAGES);
  localparam logic [FW-1:0] LAST_FLUSH = FW'(STAGES - 1);
  localparam logic [RW-1:0] RATE_RST   = RW'(DEF_RATE);

  state_t        r_state, w_state_n;
  logic [RW-1:0] r_phase, w_phase_n;
  logic [RW-1:0] r_rate, w_rate_n;
  logic [RW-1:0] r_pend_rate, w_pend_rate_n;
  logic          r_pend, w_pend_n;
  logic [FW-1:0] r_flush, w_flush_n;
  logic          r_valid, w_valid_n;
  logic          r_overrun, w_overrun_n;
  logic          r_rate_err, w_rate_err_n;

  logic w_int_ce;
  logic w_comb_ce;
  logic w_load_ok;

  assign w_int_ce  = i_ce && (r_state != IDLE);
  assign w_comb_ce = w_int_ce && (r_phase == (r_rate - RW'(1)));
  assign w_load_ok = i_rate_load && (i_rate != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_rate      <= RATE_RST;
      r_pend_rate <= '0;
      r_pend      <= 1'b0;
      r_flush     <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_rate_err  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_phase     <= w_phase_n;
      r_rate      <= w_rate_n;
      r_pend_rate <= w_pend_rate_n;
      r_pend      <= w_pend_n;
      r_flush     <= w_flush_n;
      r_valid     <= w_valid_n;
      r_overrun   <= w_overrun_n;
      r_rate_err  <= w_rate_err_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_phase_n     = r_phase;
    w_rate_n      = r_rate;
    w_pend_rate_n = r_pend_rate;
    w_pend_n      = r_pend;
    w_flush_n     = r_flush;
    w_valid_n     = r_valid;
    w_overrun_n   = r_overrun;
    w_rate_err_n  = i_rate_load && (i_rate == '0);

    case (r_state)
      IDLE: begin
        w_valid_n = 1'b0;
        w_phase_n = '0;
        w_flush_n = '0;
        w_pend_n  = 1'b0;
        if (w_load_ok) w_rate_n = i_rate;
        if (i_enable)  w_state_n = FLUSH;
      end
      FLUSH, RUN: begin
        if (!i_enable) begin
          w_state_n = IDLE;
          w_valid_n = 1'b0;
          w_phase_n = '0;
          w_flush_n = '0;
          w_pend_n  = 1'b0;
        end else begin
          if (r_valid && i_ready) w_valid_n = 1'b0;
          if (w_int_ce) w_phase_n = w_comb_ce ? '0 : r_phase + RW'(1);
          if (w_comb_ce) begin
            // A pending ratio takes over on this boundary; its pulse is discarded.
            if (r_pend) begin
              w_rate_n  = r_pend_rate;
              w_state_n = FLUSH;
              w_flush_n = '0;
              w_pend_n  = 1'b0;
            end else if (r_state == FLUSH) begin
              if (r_flush == LAST_FLUSH) begin
                w_state_n = RUN;
                w_flush_n = '0;
              end else begin
                w_flush_n = r_flush + FW'(1);
              end
            end else begin
              w_valid_n = 1'b1;
              if (r_valid && !i_ready) w_overrun_n = 1'b1;
            end
          end
          if (w_load_ok) begin
            w_pend_n      = 1'b1;
            w_pend_rate_n = i_rate;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign o_int_ce   = w_int_ce;
  assign o_comb_ce  = w_comb_ce;
  assign o_phase    = r_phase;
  assign o_rate     = r_rate;
  assign o_valid    = r_valid;
  assign o_state    = r_state;
  assign o_overrun  = r_overrun;
  assign o_rate_err = r_rate_err;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - directed vector bench for cic_decim_ctrl.
module tb_cic_decim_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_ce, i_rate_load, i_ready;
  logic [15:0] i_rate;
  logic        o_int_ce, o_comb_ce, o_valid, o_overrun, o_rate_err;
  logic [15:0] o_phase, o_rate;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cic_decim_ctrl #(.RW(16), .STAGES(4), .DEF_RATE(5)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_ce(i_ce),
    .i_rate(i_rate), .i_rate_load(i_rate_load), .i_ready(i_ready),
    .o_int_ce(o_int_ce), .o_comb_ce(o_comb_ce), .o_phase(o_phase),
    .o_rate(o_rate), .o_valid(o_valid), .o_state(o_state),
    .o_overrun(o_overrun), .o_rate_err(o_rate_err)
  );

  typedef struct {
    logic        ld;
    logic [15:0] rin;
    logic        rdy;
    logic [15:0] ph;
    logic [15:0] rt;
    logic [1:0]  st;
    logic        comb;
    logic        vld;
    logic        err;
    logic        ov;
  } vec_t;

  vec_t t1[20];
  vec_t t2[11];

  function automatic vec_t mk(logic ld, logic [15:0] rin, logic rdy, logic [15:0] ph,
                              logic [15:0] rt, logic [1:0] st, logic comb, logic vld,
                              logic err, logic ov);
    vec_t v;
    v.ld = ld; v.rin = rin; v.rdy = rdy; v.ph = ph; v.rt = rt; v.st = st;
    v.comb = comb; v.vld = vld; v.err = err; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    i_enable = 1'b1; i_ce = 1'b1; i_rate_load = v.ld; i_rate = v.rin; i_ready = v.rdy;
    #1;
    chk({tag, "_phase"}, idx, o_phase, v.ph);
    chk({tag, "_rate"}, idx, o_rate, v.rt);
    chk({tag, "_state"}, idx, o_state, v.st);
    chk({tag, "_comb"}, idx, o_comb_ce, v.comb);
    chk({tag, "_int"}, idx, o_int_ce, (v.st != 2'd0));
    chk({tag, "_valid"}, idx, o_valid, v.vld);
    chk({tag, "_err"}, idx, o_rate_err, v.err);
    chk({tag, "_ovr"}, idx, o_overrun, v.ov);
    cyc();
  endtask

  task automatic do_reset;
    i_reset = 1'b1; i_enable = 1'b0; i_ce = 1'b0; i_rate_load = 1'b0;
    i_rate = 16'd0; i_ready = 1'b0;
    cyc(); cyc();
    i_reset = 1'b0;
  endtask

  initial begin
    // Rate change 5->3 requested at phase 1 of a RUN period, then a rejected load.
    t1[0]  = mk(1, 3, 1, 1, 5, 2, 0, 0, 0, 0);
    t1[1]  = mk(0, 0, 1, 2, 5, 2, 0, 0, 0, 0);
    t1[2]  = mk(0, 0, 1, 3, 5, 2, 0, 0, 0, 0);
    t1[3]  = mk(0, 0, 1, 4, 5, 2, 1, 0, 0, 0);
    t1[4]  = mk(0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    t1[5]  = mk(0, 0, 1, 1, 3, 1, 0, 0, 0, 0);
    t1[6]  = mk(0, 0, 1, 2, 3, 1, 1, 0, 0, 0);
    t1[7]  = mk(1, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    t1[8]  = mk(0, 0, 1, 1, 3, 1, 0, 0, 1, 0);
    t1[9]  = mk(0, 0, 1, 2, 3, 1, 1, 0, 0, 0);
    t1[10] = mk(0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    t1[11] = mk(0, 0, 1, 1, 3, 1, 0, 0, 0, 0);
    t1[12] = mk(0, 0, 1, 2, 3, 1, 1, 0, 0, 0);
    t1[13] = mk(0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    t1[14] = mk(0, 0, 1, 1, 3, 1, 0, 0, 0, 0);
    t1[15] = mk(0, 0, 1, 2, 3, 1, 1, 0, 0, 0);
    t1[16] = mk(0, 0, 1, 0, 3, 2, 0, 0, 0, 0);
    t1[17] = mk(0, 0, 1, 1, 3, 2, 0, 0, 0, 0);
    t1[18] = mk(0, 0, 1, 2, 3, 2, 1, 0, 0, 0);
    t1[19] = mk(0, 0, 1, 0, 3, 2, 0, 1, 0, 0);

    // R=2 in RUN: transfer coinciding with comb, then two comb pulses without ready.
    t2[0]  = mk(0, 0, 1, 0, 2, 2, 0, 0, 0, 0);
    t2[1]  = mk(0, 0, 1, 1, 2, 2, 1, 0, 0, 0);
    t2[2]  = mk(0, 0, 0, 0, 2, 2, 0, 1, 0, 0);
    t2[3]  = mk(0, 0, 1, 1, 2, 2, 1, 1, 0, 0);
    t2[4]  = mk(0, 0, 1, 0, 2, 2, 0, 1, 0, 0);
    t2[5]  = mk(0, 0, 0, 1, 2, 2, 1, 0, 0, 0);
    t2[6]  = mk(0, 0, 0, 0, 2, 2, 0, 1, 0, 0);
    t2[7]  = mk(0, 0, 0, 1, 2, 2, 1, 1, 0, 0);
    t2[8]  = mk(0, 0, 1, 0, 2, 2, 0, 1, 0, 1);
    t2[9]  = mk(0, 0, 1, 1, 2, 2, 1, 0, 0, 1);
    t2[10] = mk(0, 0, 1, 0, 2, 2, 0, 1, 0, 1);

    // Reset state, then startup flush with the default ratio.
    do_reset();
    #1;
    chk("rst_state", 0, o_state, 0);
    chk("rst_phase", 0, o_phase, 0);
    chk("rst_rate", 0, o_rate, 5);
    chk("rst_valid", 0, o_valid, 0);
    chk("rst_ovr", 0, o_overrun, 0);
    chk("rst_err", 0, o_rate_err, 0);
    i_ce = 1'b1;
    #1;
    chk("idle_int", 0, o_int_ce, 0);
    chk("idle_comb", 0, o_comb_ce, 0);
    i_enable = 1'b1; i_ready = 1'b1;
    cyc();
    for (int k = 0; k < 26; k++) begin
      #1;
      chk("start_state", k, o_state, (k < 20) ? 1 : 2);
      chk("start_phase", k, o_phase, k % 5);
      chk("start_comb", k, o_comb_ce, (k % 5) == 4);
      chk("start_int", k, o_int_ce, 1);
      chk("start_valid", k, o_valid, k == 25);
      cyc();
    end

    for (int i = 0; i < 20; i++) apply(t1[i], "ratechg", i);

    // Rejected load in IDLE, immediate load in IDLE, then overrun/handshake table.
    do_reset();
    i_rate_load = 1'b1; i_rate = 16'd0;
    cyc();
    i_rate_load = 1'b0;
    #1;
    chk("idle_err_pulse", 0, o_rate_err, 1);
    chk("idle_err_rate", 0, o_rate, 5);
    cyc();
    chk("idle_err_clear", 0, o_rate_err, 0);
    i_rate_load = 1'b1; i_rate = 16'd2;
    cyc();
    i_rate_load = 1'b0;
    #1;
    chk("idle_load_rate", 0, o_rate, 2);
    chk("idle_load_state", 0, o_state, 0);
    i_enable = 1'b1; i_ce = 1'b1; i_ready = 1'b1;
    cyc();
    for (int n = 0; n < 40; n++) begin
      #1;
      if (o_state == 2'd2) break;
      cyc();
    end
    chk("r2_run_reached", 0, o_state, 2);
    for (int i = 0; i < 11; i++) apply(t2[i], "hs", i);

    // Disable mid-FLUSH with a pending load; re-enable must redo a full flush at R=5.
    do_reset();
    i_enable = 1'b1; i_ce = 1'b1; i_ready = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) cyc();
    chk("dis_pre_state", 0, o_state, 1);
    i_rate_load = 1'b1; i_rate = 16'd7;
    cyc();
    i_rate_load = 1'b0;
    #1;
    chk("dis_pend_rate", 0, o_rate, 5);
    i_enable = 1'b0;
    cyc();
    chk("dis_state", 0, o_state, 0);
    chk("dis_phase", 0, o_phase, 0);
    chk("dis_rate", 0, o_rate, 5);
    chk("dis_valid", 0, o_valid, 0);
    cyc();
    chk("dis_rate_hold", 0, o_rate, 5);
    i_enable = 1'b1;
    cyc();
    begin
      int n;
      for (n = 0; n < 30; n++) begin
        #1;
        if (o_state == 2'd2) break;
        cyc();
      end
      chk("reflush_len", 0, n, 20);
    end
    chk("reflush_rate", 0, o_rate, 5);

    // Reset in RUN with valid and overrun set; a rejected load during reset must not pulse.
    i_ready = 1'b0;
    for (int k = 0; k < 11; k++) cyc();
    chk("pre_rst_valid", 0, o_valid, 1);
    chk("pre_rst_ovr", 0, o_overrun, 1);
    i_reset = 1'b1; i_rate_load = 1'b1; i_rate = 16'd0;
    cyc();
    chk("mid_rst_state", 0, o_state, 0);
    chk("mid_rst_phase", 0, o_phase, 0);
    chk("mid_rst_rate", 0, o_rate, 5);
    chk("mid_rst_valid", 0, o_valid, 0);
    chk("mid_rst_ovr", 0, o_overrun, 0);
    chk("mid_rst_err", 0, o_rate_err, 0);
    chk("mid_rst_int", 0, o_int_ce, 0);
    chk("mid_rst_comb", 0, o_comb_ce, 0);
    i_reset = 1'b0; i_rate_load = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
